// File: rtl/message_sender.sv
// Walks the message ROM from address 0 to MSG_LEN-1 and hands each byte to the UART transmitter.
// Byte period is 3 cycles when tx_busy stays low; start is honoured only in IDLE and tx_busy stalls SEND.
module message_sender #(
    parameter int MSG_LEN = 14,
    parameter int ADDR_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    input  logic              tx_busy,
    output logic [7:0]        tx_data,
    output logic              new_tx_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        SEND    = 2'd2,
        ADVANCE = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MSG_LEN - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              new_tx_data_q, new_tx_data_d;
    logic              done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rom_addr_q    <= '0;
            tx_data_q     <= 8'h00;
            new_tx_data_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rom_addr_q    <= rom_addr_d;
            tx_data_q     <= tx_data_d;
            new_tx_data_q <= new_tx_data_d;
            done_q        <= done_d;
        end
    end

    // Strobe and done are single-cycle: they default low and are set only on the transition edge.
    always_comb begin
        state_d       = state_q;
        rom_addr_d    = rom_addr_q;
        tx_data_d     = tx_data_q;
        new_tx_data_d = 1'b0;
        done_d        = 1'b0;
        unique case (state_q)
            IDLE: begin
                rom_addr_d = '0;
                if (start) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = SEND;
            end
            SEND: begin
                if (!tx_busy) begin
                    tx_data_d     = rom_data;
                    new_tx_data_d = 1'b1;
                    state_d       = ADVANCE;
                end
            end
            ADVANCE: begin
                if (rom_addr_q == LAST_ADDR) begin
                    rom_addr_d = '0;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end else begin
                    rom_addr_d = rom_addr_q + 1'b1;
                    state_d    = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rom_addr    = rom_addr_q;
    assign tx_data     = tx_data_q;
    assign new_tx_data = new_tx_data_q;
    assign done        = done_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: doc/message_sender.md
# message_sender

Sequencer that sits directly downstream of the 14-entry message ROM and feeds the UART transmitter. On a start request it walks the ROM addresses 0 to MSG_LEN-1 and absorbs the ROM's one-cycle registered read latency. It hands each byte to the transmitter with a single-cycle strobe, pacing on the transmitter's busy flag, and pulses `done` when the whole message has been queued.

## Interface
Parameters:
- `MSG_LEN`, 14: number of ROM entries sent per message; range 1..16.
- `ADDR_W`, 4: ROM address width; requires 2^ADDR_W >= MSG_LEN.

Ports:
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- `start` in 1: level-sampled request to send the message; honoured only in IDLE.
- `rom_addr` out ADDR_W: address to the message ROM; registered.
- `rom_data` in 8: ROM read data; valid the cycle after `rom_addr` is presented.
- `tx_busy` in 1: transmitter busy; a strobe is issued only when it is low.
- `tx_data` out 8: byte to the transmitter; registered and held between strobes.
- `new_tx_data` out 1: one-cycle strobe; `tx_data` is valid in the same cycle.
- `busy` out 1: high in every non-IDLE state.
- `done` out 1: one-cycle pulse in the first IDLE cycle after the last byte.

## Operation
- States:
  - IDLE: `rom_addr`=0. On `start`=1, go to FETCH.
  - FETCH: single cycle in which `rom_addr` is stable and the ROM registers it. Always goes to SEND.
  - SEND: waits while `tx_busy`=1. When `tx_busy`=0 at the edge, load `tx_data`<=`rom_data`, set `new_tx_data`<=1, and go to ADVANCE.
  - ADVANCE: clears `new_tx_data` at its end.
    - If `rom_addr`==MSG_LEN-1: `rom_addr`<=0, `done`<=1, go to IDLE.
    - Else: `rom_addr`<=`rom_addr`+1, go to FETCH.
- `done` clears after one cycle. `new_tx_data` is never high for two consecutive cycles.
- Address arithmetic is ADDR_W bits wide. The terminal compare is against MSG_LEN-1, so no address >= MSG_LEN is ever issued.
- `start` held high continuously re-triggers the message. The next FETCH begins the cycle after the `done` cycle, because `start` is sampled in that IDLE cycle.
- `start` asserted while `busy`=1 is ignored, not queued.
- `tx_busy` held high indefinitely stalls in SEND with no timeout. `busy` stays high and `rom_addr` is held.
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - `rom_addr`=0, `tx_data`=8'h00, `new_tx_data`=0, `busy`=0, `done`=0.
  - A partially sent message is abandoned. The next `start` restarts at address 0.

## Timing
- Reset values of all outputs are as above. They are asserted asynchronously and released on the first edge after `rst_n` rises.
- Let the `start` sample edge end cycle 0.
  - Cycle 1: FETCH, `busy`=1.
  - Cycle 2: SEND.
  - Cycle 3: first strobe.
- With `tx_busy` always low, byte k is strobed in cycle 3+3k, i.e. a 3-cycle byte period.
- For MSG_LEN=14, the last strobe is in cycle 42, and cycle 43 has `done`=1, `busy`=0, `rom_addr`=0.
- Each cycle `tx_busy` is sampled high in SEND adds exactly one cycle before that byte's strobe.
- The transmitter must raise `tx_busy` within 2 cycles of a strobe. The FETCH cycle after ADVANCE provides that margin before SEND samples it.

## Test plan
- Reset then `start` pulse, with a ROM model holding "HELLO WORLD!\n\r" and `tx_busy`=0:
  - 14 strobes in cycles 3,6,…,42.
  - `tx_data` sequence is 48 45 4C 4C 4F 20 57 4F 52 4C 44 21 0A 0D.
  - `done` in cycle 43.
- UART model asserting `tx_busy` for 10 cycles after each strobe:
  - Strobe spacing is 11 cycles (10 busy cycles plus one in SEND).
  - Byte order is unchanged and no strobe occurs while `tx_busy`=1.
- `start` pulsed again in cycles 5 and 20 of a send:
  - Both pulses are ignored.
  - Exactly 14 strobes, one `done`.
- `rst_n` asserted low mid-message, between the strobes for bytes 5 and 6:
  - Outputs go to reset values immediately.
  - The next `start` yields first byte 0x48 from `rom_addr`=0.
- `start` held high for 100 cycles with `tx_busy`=0:
  - Back-to-back messages.
  - `done` in cycles 43 and 86.
  - The second message's first strobe is in cycle 46.
- MSG_LEN=1 build:
  - A single strobe with 0x48 in cycle 3, `done` in cycle 4.
  - `rom_addr` never leaves 0.
